candidate_match_reader: RTL
===========================

# candidate_match_reader

Consumer end of the candidate-match memory. Once per BX it reads back the page the writer filled during the previous BX. The writer's entry count tells it how many words to fetch. It issues read addresses with credit-based flow control against the memory read latency and streams the 12-bit matches to the downstream match calculator through a valid/ready skid FIFO. It sits directly after the candidate-match memory in the match-engine chain.

## Interface
- MEM_SIZE, 5: page address width; one page holds 2**MEM_SIZE entries.
- DATA_WIDTH, 12: match word width.
- RD_LATENCY, 2: cycles from `read_add` to valid memory `data_in`.
- TMUX, 6: `start`-to-`done` delay in cycles.
- FIFO_DEPTH, 4: output skid FIFO depth; must be at least RD_LATENCY+2.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- en_proc  in  1  read-issue enable.
- start  in  2  [0] new-BX strobe, [1] pipelined synchronous flush.
- done  out  2  `start` delayed TMUX cycles.
- number_in  in  6  entry count from the writer, valid from cycle 2 after `start[0]`.
- read_add  out  MEM_SIZE+3  memory read address.
- data_in  in  DATA_WIDTH  memory read data.
- data_out  out  DATA_WIDTH  match word to downstream.
- valid_out  out  1  `data_out` valid.
- ready_in  in  1  downstream accepts the word when `valid_out` and `ready_in` are both high.
- overflow  out  1  one-cycle pulse when a BX is abandoned before all words were issued.

## Operation
- BX counter `bx[2:0]` resets to 3'b111 and increments on `start[0]`.
- Read page is the value of `bx[0]` before the increment, i.e. the page written in the previous BX.
- `read_add` is {2'b00, page, idx[MEM_SIZE-1:0]}.
- FSM states and transitions:
  - IDLE: on `start[0]`, latch the page and go to WAIT.
  - WAIT: two cycles. On the second cycle, sample `number_in` into `cnt`.
  - Count clamp: `cnt` is clamped to 2**MEM_SIZE. Example: 40 becomes 32 when MEM_SIZE=5.
  - WAIT exit: `cnt`==0 goes to IDLE, otherwise go to READ with `idx`=0.
  - READ: issue one read per cycle when `en_proc` is high and `fifo_count + inflight < FIFO_DEPTH`; then increment `idx`.
  - READ exit: go to IDLE after the read with `idx`==`cnt`-1 is issued.
- Read valid is delayed by an RD_LATENCY-stage shift register.
- Memory data is pushed into the FIFO when the delayed valid arrives. Because issue is credit-gated, the FIFO never overflows.
- A `start[0]` arriving in WAIT or READ abandons the remaining reads and pulses `overflow`. Reads already in flight still complete into the FIFO. The FSM restarts as if from IDLE, with the new page latched in the same cycle.
- Flush (`start[1]`) has priority over `start[0]`:
  - FSM goes to IDLE and `bx` returns to 3'b111.
  - The FIFO and in-flight pipe are cleared.
  - `overflow` stays 0.
- Reset values: `done`=0, `read_add`=0, `data_out`=0, `valid_out`=0, `overflow`=0. The FSM is in IDLE and `bx`=3'b111.

## Timing
- `start[0]` high in cycle 0; `number_in` is sampled in cycle 2.
- First `read_add` appears in cycle 3. The matching `data_in` arrives in cycle 3+RD_LATENCY and is written at the end of that cycle.
- First `valid_out` is in cycle 4+RD_LATENCY (cycle 6 at the default).
- Steady state with `ready_in` held high: one word per cycle, no bubbles.
- `data_out` is held stable while `valid_out` is high and `ready_in` is low.
- `done` equals `start` delayed exactly TMUX cycles and is unaffected by the flush.

## Structure
- Shared package: DATA_WIDTH and MEM_SIZE constants, the FSM state enum {IDLE, WAIT, READ}, and a `page_addr` function that builds `read_add`.
- Reuse the existing `pipe_delay` for `done`.
- One natural sub-module: `match_skid_fifo`, a synchronous FIFO of FIFO_DEPTH with a count output and a synchronous clear.

## Test plan
- Writer reports 3 entries; memory holds A,B,C at page 1, indices 0-2, with `ready_in`=1 -> `read_add` is 0x20,0x21,0x22 in cycles 3-5; A,B,C are valid in cycles 6-8; `overflow`=0.
- `number_in`=0 -> no `read_add` change, no `valid_out`; FSM returns to IDLE in cycle 3.
- `number_in`=40 with MEM_SIZE=5 -> exactly 32 reads, covering idx 0-31.
- `ready_in` toggled 1/0 every cycle over 10 entries -> all 10 words delivered in order with no loss or duplication; FIFO never exceeds 4.
- `start[0]` reasserted after 5 of 20 reads -> `overflow` pulses once; the 5 issued words are delivered; reading resumes on the other page.
- `start[1]` mid-READ, then an async `reset` pulse during streaming -> outputs return to reset values immediately; the next BX reads page 1 again.

Source files
------------

// File: rtl/candidate_match_reader_pkg.sv
// Shared constants, FSM state type and address helper for the candidate-match reader.
package candidate_match_reader_pkg;
  localparam int MEM_SIZE   = 5;
  localparam int DATA_WIDTH = 12;
  localparam int ADDR_WIDTH = MEM_SIZE + 3;
  localparam int CNT_WIDTH  = MEM_SIZE + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, READ = 2'd2} state_e;

  // Memory address: two spare high bits, the page bit, then the entry index.
  function automatic logic [ADDR_WIDTH-1:0] page_addr(input logic page,
                                                      input logic [MEM_SIZE-1:0] idx);
    return {2'b00, page, idx};
  endfunction
endpackage

// File: rtl/match_skid_fifo.sv
// Small synchronous FIFO with occupancy count and synchronous clear; head word shows zero when empty.
module match_skid_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign valid    = (count != '0);
  assign pop_data = valid ? mem[rd_ptr] : '0;
  assign do_pop   = pop && valid;
  assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line, reset to zero.
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];
endmodule

// File: rtl/candidate_match_reader.sv
// Reads back the candidate-match page filled in the previous BX and streams it downstream.
// Handshake: a word moves when valid_out && ready_in; data_out is stable while valid_out waits.
module candidate_match_reader
  import candidate_match_reader_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int TMUX       = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_proc,
  input  logic [1:0]            start,
  output logic [1:0]            done,
  input  logic [5:0]            number_in,
  output logic [ADDR_WIDTH-1:0] read_add,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  overflow,
  output state_e                fsm_state
);
  localparam int         FCW          = $clog2(FIFO_DEPTH + 1);
  localparam logic [5:0] PAGE_ENTRIES = 6'(2 ** MEM_SIZE);

  state_e                state, next_state;
  logic [2:0]            bx;
  logic                  page, wait_cnt;
  logic [CNT_WIDTH-1:0]  cnt, idx, clamped;
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [ADDR_WIDTH-1:0] last_add;
  logic                  issue, flush, new_bx, pop;
  logic [FCW-1:0]        fifo_count;
  logic [FCW:0]          used;

  assign flush     = start[1];
  assign new_bx    = start[0] & ~start[1];
  assign clamped   = (number_in > PAGE_ENTRIES) ? CNT_WIDTH'(PAGE_ENTRIES) : CNT_WIDTH'(number_in);
  assign pop       = valid_out & ready_in;
  assign fsm_state = state;

  // Credits: words already queued plus reads still in the memory pipe.
  always_comb begin
    used = (FCW+1)'(fifo_count);
    for (int i = 0; i < RD_LATENCY; i++) used = used + (FCW+1)'(rd_pipe[i]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (flush)       next_state = IDLE;
    else if (new_bx) next_state = WAIT;
    else begin
      case (state)
        WAIT:    if (wait_cnt) next_state = (clamped == '0) ? IDLE : READ;
        READ:    if (issue && (idx == cnt - CNT_WIDTH'(1))) next_state = IDLE;
        default: next_state = state;
      endcase
    end
  end

  // A strobe in the same cycle preempts the read that would otherwise issue.
  always_comb begin
    issue    = (state == READ) && en_proc && (start == 2'b00) &&
               (used < (FCW+1)'(FIFO_DEPTH));
    read_add = issue ? page_addr(page, idx[MEM_SIZE-1:0]) : last_add;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bx       <= 3'b111;
      page     <= 1'b0;
      wait_cnt <= 1'b0;
      cnt      <= '0;
      idx      <= '0;
      last_add <= '0;
      overflow <= 1'b0;
      rd_pipe  <= '0;
    end else begin
      overflow <= new_bx && (state != IDLE);
      if (issue) last_add <= read_add;
      rd_pipe  <= flush ? '0 : ((rd_pipe << 1) | RD_LATENCY'(issue));
      if (flush) begin
        bx       <= 3'b111;
        wait_cnt <= 1'b0;
      end else if (new_bx) begin
        bx       <= bx + 3'd1;
        page     <= bx[0];
        wait_cnt <= 1'b0;
      end else if (state == WAIT) begin
        wait_cnt <= 1'b1;
        if (wait_cnt) begin
          cnt <= clamped;
          idx <= '0;
        end
      end else if (issue) begin
        idx <= idx + CNT_WIDTH'(1);
      end
    end
  end

  match_skid_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (rd_pipe[RD_LATENCY-1] & ~flush),
    .push_data (data_in),
    .pop       (pop),
    .pop_data  (data_out),
    .valid     (valid_out),
    .count     (fifo_count)
  );

  pipe_delay #(.WIDTH(2), .DEPTH(TMUX)) u_done (
    .clk   (clk),
    .reset (reset),
    .din   (start),
    .dout  (done)
  );
endmodule
